// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache with byte-serial refill.
// Define ICACHE_STATS_EN to build the hit/miss counters.
module icache #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 16 - INDEX_BITS
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_byte,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_RESP
    } state_t;

    state_t state_q, state_d;

    logic [31:0]         data_mem [LINES];
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [LINES-1:0]    valid_q;

    logic [29:0] line_q, line_d;
    logic [1:0]  req_k_q, req_k_d;
    logic [1:0]  recv_k_q, recv_k_d;
    logic        pend_q, pend_d;
    logic [23:0] word_q, word_d;

    logic        inst_valid_d;
    logic [31:0] inst_d;
    logic        mem_req_d;
    logic [31:0] mem_addr_d;
    logic        line_we;
    logic        hit_inc;
    logic        miss_inc;

    logic [INDEX_BITS-1:0] f_idx, r_idx;
    logic [TAG_BITS-1:0]   f_tag, r_tag;
    logic                  hit;

    assign f_idx = fetch_addr[2 +: INDEX_BITS];
    assign f_tag = fetch_addr[17 -: TAG_BITS];
    assign r_idx = line_q[INDEX_BITS-1:0];
    assign r_tag = line_q[15 -: TAG_BITS];
    assign hit   = valid_q[f_idx] && (tag_mem[f_idx] == f_tag);

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        req_k_d      = req_k_q;
        recv_k_d     = recv_k_q;
        pend_d       = 1'b0;
        word_d       = word_q;
        inst_valid_d = 1'b0;
        inst_d       = inst;
        mem_req_d    = mem_req;
        mem_addr_d   = mem_addr;
        line_we      = 1'b0;
        hit_inc      = 1'b0;
        miss_inc     = 1'b0;

        if (clear) begin
            state_d   = S_IDLE;
            req_k_d   = 2'd0;
            recv_k_d  = 2'd0;
            mem_req_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (fetch_req && hit) begin
                        inst_valid_d = 1'b1;
                        inst_d       = data_mem[f_idx];
                        hit_inc      = 1'b1;
                    end else if (fetch_req) begin
                        line_d     = fetch_addr[31:2];
                        req_k_d    = 2'd0;
                        recv_k_d   = 2'd0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {fetch_addr[31:2], 2'b00};
                        miss_inc   = 1'b1;
                        state_d    = S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (mem_req && mem_gnt) begin
                        req_k_d = req_k_q + 2'd1;
                        pend_d  = 1'b1;
                        if (req_k_q == 2'd3) begin
                            mem_req_d = 1'b0;
                        end else begin
                            mem_addr_d = {line_q, req_k_q + 2'd1};
                        end
                    end
                    // Last lane goes straight to the line and the output.
                    if (pend_q) begin
                        recv_k_d = recv_k_q + 2'd1;
                        case (recv_k_q)
                            2'd0: word_d[7:0]   = mem_byte;
                            2'd1: word_d[15:8]  = mem_byte;
                            2'd2: word_d[23:16] = mem_byte;
                            default: begin
                                line_we      = 1'b1;
                                inst_valid_d = 1'b1;
                                inst_d       = {mem_byte, word_q};
                                state_d      = S_RESP;
                            end
                        endcase
                    end
                end
                S_RESP: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            line_q     <= '0;
            req_k_q    <= 2'd0;
            recv_k_q   <= 2'd0;
            pend_q     <= 1'b0;
            word_q     <= '0;
            inst_valid <= 1'b0;
            inst       <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            line_q     <= line_d;
            req_k_q    <= req_k_d;
            recv_k_q   <= recv_k_d;
            pend_q     <= pend_d;
            word_q     <= word_d;
            inst_valid <= inst_valid_d;
            inst       <= inst_d;
            mem_req    <= mem_req_d;
            mem_addr   <= mem_addr_d;
            if (line_we) begin
                valid_q[r_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && line_we) begin
            data_mem[r_idx] <= {mem_byte, word_q};
            tag_mem[r_idx]  <= r_tag;
        end
    end

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^fetch_addr[1:0];

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_q, miss_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (rdy_in) begin
            if (hit_inc) begin
                hit_q <= hit_q + 32'd1;
            end
            if (miss_inc) begin
                miss_q <= miss_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`else
    logic unused_stats;
    assign unused_stats = hit_inc ^ miss_inc;
    assign hit_cnt      = '0;
    assign miss_cnt     = '0;
`endif

endmodule

// File: doc/icache.md
# icache

Direct-mapped, word-line instruction cache between the fetch stage and the memory controller inside the RV32I core. Fetch presents a word-aligned PC and receives the 32-bit little-endian instruction. Hits return in one cycle. Misses refill the line with four byte reads through the controller's one-byte-per-cycle port. A pipeline flush (`clear`) aborts any lookup or refill in progress.

## Interface
- `INDEX_BITS`, 6, line-index width; lines = 2^INDEX_BITS, one 32-bit word per line.
- `TAG_BITS`, 16-INDEX_BITS, tag width, taken from addr[17:2+INDEX_BITS].

Ports:
- `clk_in`, in, 1: single clock, all state on rising edge.
- `rst_in`, in, 1: synchronous, active-high reset.
- `rdy_in`, in, 1: when low, freeze all state; outputs hold.
- `clear`, in, 1: flush; abort current request or refill.
- `fetch_req`, in, 1: fetch requests the instruction at `fetch_addr`.
- `fetch_addr`, in, 32: PC; bits [1:0] ignored, bits above 17 ignored.
- `inst_valid`, out, 1: one-cycle pulse, `inst` valid.
- `inst`, out, 32: instruction word.
- `mem_req`, out, 1: byte read request to memory controller.
- `mem_addr`, out, 32: byte address of the request.
- `mem_gnt`, in, 1: controller accepts `mem_addr` this cycle.
- `mem_byte`, in, 8: read data, valid the cycle after a grant.
- `hit_cnt`, out, 32: hit counter (see Configuration).
- `miss_cnt`, out, 32: miss counter (see Configuration).

## Operation
- Storage: data[2^INDEX_BITS] x 32, tag[] x TAG_BITS, valid[] x 1. Reset clears all valid bits; data and tag are not reset.
- Address split: index = addr[2+INDEX_BITS-1:2]; tag = addr[17:2+INDEX_BITS].
- State machine:
  - IDLE:
    - `fetch_req` with valid and tag match: register the word and pulse `inst_valid` next cycle; stay in IDLE.
    - `fetch_req` with no match: latch the address and go to REFILL with byte counter req_k=0 and recv_k=0.
  - REFILL:
    - Drive `mem_req`=1 and `mem_addr`={addr[31:2],req_k[1:0]} while req_k<4.
    - `mem_gnt`: increment req_k and set a pending flag for the next cycle.
    - Pending flag set: write `mem_byte` into byte lane recv_k, then increment recv_k.
    - Fourth byte received: write data, tag and valid=1; go to RESP.
  - RESP: pulse `inst_valid` with the assembled word; go to IDLE.
- Byte order: lane k holds bits [8k+7:8k], little-endian.
- Fetch holds `fetch_req` and `fetch_addr` stable until `inst_valid`. An address change while in REFILL is ignored; only `clear` redirects.
- `clear` in any state, highest priority:
  - Go to IDLE, zero the counters, drop the pending flag, suppress `inst_valid` and leave the line untouched.
  - A byte returning the cycle after `clear` is discarded.
  - `fetch_req` in the same cycle as `clear` is ignored.
- `rst_in` mid-refill: same as `clear`, and additionally clears all valid bits.
- Reset values: `inst_valid`=0, `inst`=0, `mem_req`=0, `mem_addr`=0, `hit_cnt`=0, `miss_cnt`=0; state IDLE.
- `rdy_in` low: no state update, including counters and the pending flag.
  - The memory controller is frozen on the same signal, so no byte is lost.
  - `mem_req` and `mem_addr` hold their values.

## Timing
- Hit: `fetch_req` in cycle N, `inst_valid` in N+1.
- Miss with continuous grants:
  - Requests are granted in N+1 to N+4.
  - Bytes arrive in N+2 to N+5.
  - Line is written at the end of N+5; `inst_valid` in N+6.
- Each cycle without a grant delays the remaining schedule by one cycle.
- The pulse is back-to-back capable: a new `fetch_req` is accepted in the `inst_valid` cycle of a hit, but not in the RESP cycle of a miss.
- `mem_req` is registered; `mem_gnt` is sampled in the same cycle.

## Configuration
- `ICACHE_STATS_EN` defined: `hit_cnt` increments on each hit lookup and `miss_cnt` on each REFILL entry.
  - Both wrap modulo 2^32.
  - Neither counter increments on a request cancelled by `clear`.
- Undefined: counters are not built and both ports are tied to 0.

## Test plan
- Reset, then fetch 0x00000000 with memory bytes 13 05 00 00 and grants every cycle -> `mem_addr` sequence 0,1,2,3; `inst`=0x00000513 with `inst_valid` at N+6; `miss_cnt`=1.
- Re-fetch 0x00000000 -> `inst_valid` at N+1 with 0x00000513 and no `mem_req`; `hit_cnt`=1.
- Fetch 0x00000100 (same index 0, INDEX_BITS=6) -> miss and refill; fetch 0x00000000 again -> miss (line evicted).
- Refill with `mem_gnt` low for 3 cycles before byte 2 -> `inst_valid` delayed to N+9 and correct word assembled.
- `clear` on the cycle byte 1 arrives -> no `inst_valid`, valid bit still 0, and a new miss to the same address refetches all 4 bytes.
- `rdy_in` low for 5 cycles mid-refill -> state frozen, then completes with the correct word 5 cycles late.
